// File: rtl/if_prefetch_pkg.sv
// Shared constants and types for the instruction prefetch unit.
package if_prefetch_pkg;

   localparam logic [31:0] INST_NOP         = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam int          DEPTH_DEFAULT    = 4;

   // One buffered instruction together with the address it was fetched from.
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] inst;
   } fetch_entry_t;

   // Fetch addresses are always word aligned; the low two bits are dropped.
   function automatic logic [31:0] align_word(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; used for the instruction buffer and
// for the address tags of outstanding memory requests.
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign rdata   = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)      count <= count + (AW+1)'(1);
         else if (!do_push && do_pop) count <= count - (AW+1)'(1);
      end
   end

   // Entry storage.
   // NOTE: the storage array is deliberately not reset; only the pointers and
   // count are, and entries outside the valid window are never observed.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetch unit: issues sequential word fetches on a req/gnt/rvalid
// bus, buffers returned words in order, and hands them to the fetch stage.
// A redirect flushes the buffer, marks in-flight responses for discard and
// restarts fetching at the new address.
module if_prefetch
   import if_prefetch_pkg::*;
#(
   parameter int          DEPTH    = DEPTH_DEFAULT,
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_i,
   input  logic [31:0] redirect_addr_i,
   output logic [31:0] inst_o,
   output logic [31:0] inst_addr_o,
   output logic        inst_valid_o,
   input  logic        inst_ready_i,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [31:0]   fetch_pc;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] outstanding_nxt;
   logic [CW-1:0] discard;
   logic [CW-1:0] fifo_count;
   logic [CW-1:0] tag_count;
   logic [CW:0]   credit_used;

   logic          gnt_fire;
   logic          rsp_fire;
   logic          data_push;
   logic          data_pop;
   logic          data_full;
   logic          data_empty;
   logic          tag_full;
   logic          tag_empty;
   logic [31:0]   tag_addr;
   logic [63:0]   data_rdata;
   fetch_entry_t  push_entry;
   fetch_entry_t  head_entry;

   // Credits cover both buffered words and words still in flight, so the
   // buffer can never overflow. The request depends on registers only.
   assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};
   assign mem_req_o   = ~rst & (credit_used < (CW+1)'(DEPTH));
   assign mem_addr_o  = fetch_pc;

   assign gnt_fire  = mem_req_o & mem_gnt_i;
   // A response with nothing outstanding is a protocol error and is ignored.
   assign rsp_fire  = mem_rvalid_i & (outstanding != '0);
   // Responses are dropped while discarding old-stream words or on a redirect.
   assign data_push = rsp_fire & (discard == '0) & ~redirect_i;
   assign data_pop  = inst_valid_o & inst_ready_i;

   assign push_entry = '{addr: tag_addr, inst: mem_rdata_i};
   assign head_entry = data_rdata;

   assign inst_valid_o = ~data_empty;
   assign inst_o       = inst_valid_o ? head_entry.inst : INST_NOP;
   assign inst_addr_o  = inst_valid_o ? head_entry.addr : 32'h0;

   // Instruction buffer of {addr, inst} pairs.
   fetch_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_data_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (data_push),
      .pop   (data_pop),
      .flush (redirect_i),
      .wdata (push_entry),
      .rdata (data_rdata),
      .full  (data_full),
      .empty (data_empty),
      .count (fifo_count)
   );

   // Address tag per granted request, consumed by its response. Tags of
   // discarded requests drain naturally, so new-stream tags line up with the
   // redirect address without rewriting the queue.
   fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tag_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (gnt_fire & ~tag_full),
      .pop   (rsp_fire & ~tag_empty),
      .flush (1'b0),
      .wdata (fetch_pc),
      .rdata (tag_addr),
      .full  (tag_full),
      .empty (tag_empty),
      .count (tag_count)
   );

   // Next outstanding count after this cycle's grant and response.
   always_comb begin
      // NOTE: default assignment first so no path leaves the signal unassigned
      // and a latch cannot be inferred.
      outstanding_nxt = outstanding;
      if (gnt_fire && !rsp_fire)      outstanding_nxt = outstanding + CW'(1);
      else if (!gnt_fire && rsp_fire) outstanding_nxt = outstanding - CW'(1);
   end

   // Fetch PC, outstanding and discard counters; a redirect turns everything
   // still in flight (including this cycle's grant) into discards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
      end else begin
         outstanding <= outstanding_nxt;
         if (redirect_i) begin
            fetch_pc <= align_word(redirect_addr_i);
            discard  <= outstanding_nxt;
         end else begin
            if (gnt_fire) fetch_pc <= fetch_pc + 32'd4;
            if (rsp_fire && discard != '0) discard <= discard - CW'(1);
         end
      end
   end

   a_no_push_when_full : assert property (@(posedge clk) disable iff (rst)
      !(data_push && data_full && !data_pop));
   a_no_orphan_rvalid : assert property (@(posedge clk) disable iff (rst)
      !(mem_rvalid_i && outstanding == '0));
   a_tags_track_outstanding : assert property (@(posedge clk) disable iff (rst)
      tag_count == outstanding);

endmodule

// File: doc/if_prefetch.md
# if_prefetch

Instruction prefetch unit between the core's fetch stage and a multi-cycle instruction memory. It generates sequential fetch addresses and issues requests on a req/gnt/rvalid bus. Returned words go into a small in-order FIFO, and the unit hands instructions to `ifetch` with a valid/ready handshake. On a redirect (jump/branch) it discards in-flight and buffered words and restarts fetching at the new address.

## Interface
- `DEPTH`, 4: FIFO entries and maximum outstanding-plus-buffered words; power of 2, at least 2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset; one clock; asynchronous, active-high.
- `redirect_i`  in  1  flush and restart fetch.
- `redirect_addr_i`  in  32  new fetch address; bits [1:0] ignored (treated as 0).
- `inst_o`  out  32  head instruction; `32'h0000_0013` (NOP) when `inst_valid_o`=0.
- `inst_addr_o`  out  32  address of `inst_o`; 0 when invalid.
- `inst_valid_o`  out  1  FIFO non-empty.
- `inst_ready_i`  in  1  consumer accepts head this cycle.
- `mem_req_o`  out  1  fetch request.
- `mem_addr_o`  out  32  request address, word aligned.
- `mem_gnt_i`  in  1  request accepted this cycle.
- `mem_rvalid_i`  in  1  response data valid.
- `mem_rdata_i`  in  32  response word.

## Operation
- State registers:
  - `fetch_pc`: next address to request.
  - `outstanding`: granted requests with no response yet, 0..DEPTH.
  - `discard`: outstanding responses to drop, ≤ outstanding.
  - A FIFO of {addr, inst} pairs.
  - An address FIFO/queue tagging each outstanding request.
- Issue:
  - `mem_req_o` = (fifo_count + outstanding < DEPTH) and not in reset.
  - `mem_addr_o` = `fetch_pc`.
  - On `mem_req_o` & `mem_gnt_i`: outstanding+1, and `fetch_pc` += 4 (mod 2^32, wraps `FFFF_FFFC`→0).
- Request stability: once asserted, `mem_req_o`/`mem_addr_o` stay unchanged until gnt. The only exception is a redirect cycle, after which the address becomes the redirect address.
- Response:
  - On `mem_rvalid_i`: outstanding−1.
  - If discard>0: discard−1 and the word is dropped.
  - Otherwise the word is pushed with its tagged address.
  - Responses are in order, one per grant. An rvalid with outstanding=0 is a protocol error (assertion) and is ignored.
- Output: pop when `inst_valid_o` & `inst_ready_i`. Push and pop in the same cycle are allowed.
- Redirect (cycle t):
  - FIFO cleared.
  - `fetch_pc` ← redirect address.
  - discard ← outstanding after this cycle's gnt/rvalid updates: a gnt at t counts as old-stream, and an rvalid at t is dropped.
  - Address queue retagged so that new-stream requests start at the redirect address.
- Overflow is impossible by the credit rule. Assert that no push happens when full.

## Timing
- Reset values: `inst_valid_o`=0, `inst_o`=NOP, `inst_addr_o`=0, `mem_req_o`=0, `fetch_pc`=RESET_PC, counters 0.
- First request: `mem_req_o`=1 with `mem_addr_o`=RESET_PC in the first cycle after `rst` deasserts.
- Reset mid-operation: all state is cleared immediately. Responses to pre-reset grants are the memory's responsibility and are not tracked.
- No combinational path from `mem_gnt_i`, `mem_rvalid_i` or `mem_rdata_i` to any output. `mem_req_o` depends on registers only.
- Latency:
  - Grant at cycle t → rvalid earliest at t+1.
  - rvalid at cycle r → `inst_valid_o` at r+1.
- Throughput: with a zero-wait memory (gnt always 1, rvalid next cycle) and `inst_ready_i`=1, one instruction per cycle in steady state.
- Redirect at t:
  - `inst_valid_o`=0 at t+1.
  - `mem_addr_o`=redirect address at t+1 (request asserted if credits allow).
- Consumer stall (`inst_ready_i`=0): the head is held stable. Requests stop once fifo_count+outstanding=DEPTH.

## Structure
- Constants go in the shared defines header:
  - `INST_NOP` = 32'h0000_0013.
  - Reset PC default.
- Sub-module `fetch_fifo`: synchronous FIFO.
  - Width parameterised (here 64 bits: addr and inst).
  - Depth DEPTH.
  - Ports: push, pop, flush, full, empty, count.
  - Instantiated once for data. The outstanding-address tag queue is a second `fetch_fifo` instance of width 32.
- Top-level control: counters, pc register, discard logic.

## Test plan
- Reset then zero-wait memory returning `mem_rdata_i`=address, with ready=1 → `inst_valid_o` from cycle 3 onward, `inst_addr_o` 0,4,8,… consecutive, `inst_o`==`inst_addr_o`.
- Consumer holds ready=0 for 10 cycles → exactly 4 requests granted, `mem_req_o` low afterwards, FIFO head stays at addr 0. Releasing ready drains 0,4,8,C in order.
- Memory with 3-cycle rvalid latency and 2 outstanding; redirect to `0x100` while both are in flight → both responses dropped, next delivered `inst_addr_o`=`0x100`.
- Redirect in the same cycle as rvalid and gnt → the rvalid word is dropped, the granted request is counted as discard, and the first valid output is the redirect address.
- Redirect to `FFFF_FFF8` → outputs `FFFF_FFF8`, `FFFF_FFFC`, `0000_0000`.
- Assert `rst` mid-burst with outstanding=3 → outputs go to reset values the same cycle; after release, the first request is to RESET_PC.
